// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial feeder, MSB-first, one-word hold buffer (optional parity: SEQ_SERIALIZER_PARITY_EN)
module seq_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             Data_out,
   output logic             bit_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SEQ_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
`ifdef SEQ_SERIALIZER_PARITY_EN
   logic             par;
   logic             do_parity;
`endif

   logic accept;
   logic end_word;
   logic ld_direct;
   logic ld_hold;
   logic do_shift;
   logic go_idle;
   logic to_hold;

   // Ready depends only on the hold flag, so there is no path from load_valid.
   assign load_ready = !hold_full;
   assign accept     = load_valid && !hold_full;
   assign busy       = (state != IDLE) || hold_full;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-edge datapath controls; the word end decides hold drain, direct load or idle.
   always_comb begin
      state_nxt = state;
      end_word  = 1'b0;
      ld_direct = 1'b0;
      ld_hold   = 1'b0;
      do_shift  = 1'b0;
      go_idle   = 1'b0;
      to_hold   = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      do_parity = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               ld_direct = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt != '0) begin
               do_shift = 1'b1;
               to_hold  = accept;
            end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
               do_parity = 1'b1;
               to_hold   = accept;
               state_nxt = PARITY;
`else
               end_word  = 1'b1;
`endif
            end
         end
`ifdef SEQ_SERIALIZER_PARITY_EN
         PARITY: begin
            end_word = 1'b1;
         end
`endif
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (end_word) begin
         if (hold_full) begin
            ld_hold   = 1'b1;
            state_nxt = SHIFT;
         end else if (accept) begin
            ld_direct = 1'b1;
            state_nxt = SHIFT;
         end else begin
            go_idle   = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   // Shifter, counter, hold buffer and registered serial outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh        <= '0;
         cnt       <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         Data_out  <= 1'b0;
         bit_valid <= 1'b0;
         word_done <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         if (ld_direct) begin
            // The MSB goes straight to the line; sh keeps the bits still to come.
            sh        <= {load_data[WIDTH-2:0], 1'b0};
            cnt       <= CW'(WIDTH - 1);
            Data_out  <= load_data[WIDTH-1];
            bit_valid <= 1'b1;
            word_done <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par       <= ^load_data;
`endif
         end else if (ld_hold) begin
            sh        <= {hold[WIDTH-2:0], 1'b0};
            cnt       <= CW'(WIDTH - 1);
            Data_out  <= hold[WIDTH-1];
            bit_valid <= 1'b1;
            word_done <= 1'b0;
            hold_full <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par       <= ^hold;
`endif
         end else if (do_shift) begin
            sh        <= {sh[WIDTH-2:0], 1'b0};
            cnt       <= cnt - CW'(1);
            Data_out  <= sh[WIDTH-1];
            bit_valid <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            word_done <= 1'b0;
`else
            word_done <= (cnt == CW'(1));
`endif
`ifdef SEQ_SERIALIZER_PARITY_EN
         end else if (do_parity) begin
            Data_out  <= par;
            bit_valid <= 1'b1;
            word_done <= 1'b1;
`endif
         end else if (go_idle) begin
            Data_out  <= 1'b0;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
         end
         // Only taken while hold is empty, so it never collides with a drain.
         if (to_hold) begin
            hold      <= load_data;
            hold_full <= 1'b1;
         end
      end
   end

endmodule
